// File: rtl/feature_feeder.sv
// Streams saturated sample*coefficient products into an external accumulator, one frame
// of FRAME_LEN samples at a time, and reports the frame sum and sticky overflow in DONE.
module feature_feeder #(
  parameter int IN_WIDTH     = 14,
  parameter int SAMPLE_WIDTH = 12,
  parameter int COEF_WIDTH   = 4,
  parameter int FRAME_LEN    = 16,
  localparam int CW          = $clog2(FRAME_LEN)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic signed [SAMPLE_WIDTH-1:0] s_data,
  input  logic signed [IN_WIDTH:0]       bias,
  input  logic                           coef_we,
  input  logic        [CW-1:0]           coef_addr,
  input  logic signed [COEF_WIDTH-1:0]   coef_wdata,
  output logic                           acc_load,
  output logic signed [IN_WIDTH:0]       acc_init,
  output logic signed [IN_WIDTH-1:0]     acc_a,
  input  logic signed [IN_WIDTH:0]       acc_y,
  input  logic                           acc_overflow,
  output logic                           sum_valid,
  output logic signed [IN_WIDTH:0]       sum,
  output logic                           sum_ovf
);

  localparam int PW = SAMPLE_WIDTH + COEF_WIDTH;
  localparam int EW = (PW > IN_WIDTH) ? PW : IN_WIDTH;
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);
  localparam logic signed [EW-1:0] SAT_MAX = {{(EW-IN_WIDTH+1){1'b0}}, {(IN_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_MIN = {{(EW-IN_WIDTH+1){1'b1}}, {(IN_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {LOAD, RUN, DRAIN, DONE} state_t;

  state_t                        state;
  logic        [CW-1:0]          idx;
  logic signed [IN_WIDTH-1:0]    prod_q;
  logic                          ovf_q;
  logic signed [COEF_WIDTH-1:0]  coef_mem [FRAME_LEN];

  logic                          accept;
  logic signed [COEF_WIDTH-1:0]  coef_cur;
  logic signed [PW-1:0]          prod_full;
  logic signed [EW-1:0]          prod_ext;
  logic signed [IN_WIDTH-1:0]    prod_sat;

  assign accept    = s_valid & s_ready;
  assign coef_cur  = coef_mem[idx];
  assign prod_full = PW'(s_data) * PW'(coef_cur);
  assign prod_ext  = EW'(prod_full);

  always_comb begin
    // NOTE: always_comb outputs get a default first so every path assigns them and no latch is inferred.
    prod_sat = prod_ext[IN_WIDTH-1:0];
    if (prod_ext > SAT_MAX)      prod_sat = SAT_MAX[IN_WIDTH-1:0];
    else if (prod_ext < SAT_MIN) prod_sat = SAT_MIN[IN_WIDTH-1:0];
  end

  // Control outputs are registered alongside the state so they change exactly with it.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOAD;
      acc_load  <= 1'b1;
      s_ready   <= 1'b0;
      sum_valid <= 1'b0;
    end else begin
      unique case (state)
        LOAD: begin
          state    <= RUN;
          acc_load <= 1'b0;
          s_ready  <= 1'b1;
        end
        RUN: begin
          if (accept && idx == LAST_IDX) begin
            state   <= DRAIN;
            s_ready <= 1'b0;
          end
        end
        DRAIN: begin
          state     <= DONE;
          sum_valid <= 1'b1;
        end
        DONE: begin
          state     <= LOAD;
          sum_valid <= 1'b0;
          acc_load  <= 1'b1;
        end
      endcase
    end
  end

  // Product register feeds the accumulator; it holds zero on cycles without an acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx    <= '0;
      prod_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      prod_q <= accept ? prod_sat : '0;
      if (state == LOAD)  idx <= '0;
      else if (accept)    idx <= idx + CW'(1);
      if (state == LOAD)  ovf_q <= 1'b0;
      else if ((state == RUN || state == DRAIN) && acc_overflow) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the coefficient table is cleared on reset so a fresh frame never uses stale weights.
      for (int i = 0; i < FRAME_LEN; i++) coef_mem[i] <= '0;
    end else if (coef_we) begin
      coef_mem[coef_addr] <= coef_wdata;
    end
  end

  assign acc_init = bias;
  assign acc_a    = prod_q;
  assign sum      = acc_y;
  assign sum_ovf  = ovf_q;

endmodule

// File: tb/tb_feature_feeder.sv
// Self-checking bench for feature_feeder driving a behavioural accumulator; expected
// sums, products and overflow come from an integer frame model.
module tb_feature_feeder;

  localparam int IW = 14, SW = 12, CFW = 4, FL = 4, CW = 2, YW = IW + 1;
  localparam int AMAX = 2**(IW-1) - 1, AMIN = -(2**(IW-1));
  localparam int YMAX = 2**IW - 1,     YMIN = -(2**IW);

  logic clk = 1'b0, reset = 1'b1, s_valid = 1'b0, coef_we = 1'b0;
  logic s_ready, acc_load, acc_overflow, sum_valid, sum_ovf;
  logic signed [SW-1:0]  s_data = '0;
  logic signed [IW:0]    bias = '0;
  logic signed [IW:0]    acc_init, acc_y, sum;
  logic        [CW-1:0]  coef_addr = '0;
  logic signed [CFW-1:0] coef_wdata = '0;
  logic signed [IW-1:0]  acc_a;

  int vectors = 0, miscompares = 0;
  int smp[FL];
  int shadow[FL];
  int pq_addr[$], pq_data[$];
  int mid_at = -1, mid_addr = 0, mid_data = 0;

  feature_feeder #(.IN_WIDTH(IW), .SAMPLE_WIDTH(SW), .COEF_WIDTH(CFW), .FRAME_LEN(FL)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .bias(bias), .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .acc_load(acc_load), .acc_init(acc_init), .acc_a(acc_a), .acc_y(acc_y),
    .acc_overflow(acc_overflow), .sum_valid(sum_valid), .sum(sum), .sum_ovf(sum_ovf)
  );

  always #5 clk = ~clk;

  // Wrapping accumulator with combinational signed-overflow flag
  logic signed [YW-1:0] acc_q = '0;
  logic signed [YW-1:0] acc_addend, acc_next;
  assign acc_addend   = YW'(acc_a);
  assign acc_next     = acc_q + acc_addend;
  assign acc_overflow = (acc_q[YW-1] == acc_addend[YW-1]) && (acc_next[YW-1] != acc_q[YW-1]);
  assign acc_y        = acc_q;
  always @(posedge clk) acc_q <= acc_load ? acc_init : acc_next;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int clamp(input int p);
    if (p > AMAX) return AMAX;
    if (p < AMIN) return AMIN;
    return p;
  endfunction

  function automatic int wrap(input int t);
    int u;
    u = (t - YMIN) % (2**YW);
    if (u < 0) u += 2**YW;
    return u + YMIN;
  endfunction

  function automatic int rnd(input int lo, input int hi);
    return lo + int'($urandom_range(0, hi - lo));
  endfunction

  task automatic queue_coefs(input int c0, input int c1, input int c2, input int c3);
    pq_addr.push_back(0); pq_data.push_back(c0);
    pq_addr.push_back(1); pq_data.push_back(c1);
    pq_addr.push_back(2); pq_data.push_back(c2);
    pq_addr.push_back(3); pq_data.push_back(c3);
  endtask

  // One frame: wait for LOAD, flush queued coefficient writes, feed smp[], check result.
  // gap >= 0 idles that many cycles between samples; gap < 0 gives random s_valid.
  task automatic run_frame(input string name, input int b, input int gap,
                           input bit use_want, input int want_sum, input int want_ovf);
    int i, cyc, idle, run_sum, run_ovf, pend_a, t, wa, wd, exp_ovf;
    bit pend;
    logic signed [IW-1:0] exp_a;
    logic signed [IW:0]   exp_sum;
    bias = YW'(b);
    cyc = 0;
    while (acc_load !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (acc_load !== 1'b1) begin
      miscompares++;
      $display("FAIL %s load_wait: acc_load=%b required 1", name, acc_load);
    end
    run_sum = b; run_ovf = 0; i = 0; idle = 0; pend = 0; pend_a = 0; cyc = 0;
    while (i < FL && cyc < 200) begin
      @(negedge clk);
      cyc++;
      coef_we = 1'b0;
      s_valid = 1'b0;
      s_data  = SW'($urandom);
      exp_a   = pend ? IW'(pend_a) : '0;
      pend    = 0;
      vectors++;
      if (acc_a !== exp_a) begin
        miscompares++;
        $display("FAIL %s run_acc_a: got %0d required %0d", name, acc_a, exp_a);
      end
      vectors++;
      if (s_ready !== 1'b1 || acc_load !== 1'b0 || sum_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL %s run_ctrl: s_ready=%b acc_load=%b sum_valid=%b required 1 0 0",
                 name, s_ready, acc_load, sum_valid);
      end
      if (pq_addr.size() > 0) begin
        wa = pq_addr.pop_front();
        wd = pq_data.pop_front();
        coef_we = 1'b1; coef_addr = CW'(wa); coef_wdata = CFW'(wd);
        shadow[wa] = wd;
      end else if ((gap >= 0 && i > 0 && idle < gap) || (gap < 0 && $urandom_range(0, 1) == 0)) begin
        idle++;
      end else begin
        s_valid = 1'b1;
        s_data  = SW'(smp[i]);
        pend_a  = clamp(smp[i] * shadow[i]);
        pend    = 1;
        t = run_sum + pend_a;
        if (t > YMAX || t < YMIN) run_ovf = 1;
        run_sum = wrap(t);
        if (i == mid_at) begin
          coef_we = 1'b1; coef_addr = CW'(mid_addr); coef_wdata = CFW'(mid_data);
          shadow[mid_addr] = mid_data;
        end
        i++;
        idle = 0;
      end
    end
    if (i < FL) begin
      vectors++;
      miscompares++;
      $display("FAIL %s sample_timeout: accepted %0d required %0d", name, i, FL);
    end
    @(negedge clk);
    coef_we = 1'b0;
    s_valid = 1'b0;
    exp_a = pend ? IW'(pend_a) : '0;
    vectors++;
    if (acc_a !== exp_a) begin
      miscompares++;
      $display("FAIL %s drain_acc_a: got %0d required %0d", name, acc_a, exp_a);
    end
    vectors++;
    if (s_ready !== 1'b0 || sum_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s drain_ctrl: s_ready=%b sum_valid=%b required 0 0", name, s_ready, sum_valid);
    end
    @(negedge clk);
    exp_sum = use_want ? YW'(want_sum) : YW'(run_sum);
    exp_ovf = use_want ? want_ovf : run_ovf;
    vectors++;
    if (sum_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s done_valid: sum_valid=%b required 1", name, sum_valid);
    end
    vectors++;
    if (sum !== exp_sum) begin
      miscompares++;
      $display("FAIL %s done_sum: got %0d required %0d", name, sum, exp_sum);
    end
    vectors++;
    if (sum_ovf !== 1'(exp_ovf)) begin
      miscompares++;
      $display("FAIL %s done_ovf: got %b required %0d", name, sum_ovf, exp_ovf);
    end
    @(negedge clk);
    vectors++;
    if (sum_valid !== 1'b0 || acc_load !== 1'b1) begin
      miscompares++;
      $display("FAIL %s reload: sum_valid=%b acc_load=%b required 0 1", name, sum_valid, acc_load);
    end
    mid_at = -1;
  endtask

  task automatic check_reset_outputs(input string name);
    vectors++;
    if (s_ready !== 1'b0 || acc_load !== 1'b1 || acc_a !== '0 || sum_valid !== 1'b0 || sum_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: s_ready=%b acc_load=%b acc_a=%0d sum_valid=%b sum_ovf=%b required 0 1 0 0 0",
               name, s_ready, acc_load, acc_a, sum_valid, sum_ovf);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_held");
    reset = 1'b0;
    #1;
    check_reset_outputs("reset_first_cycle");
    for (int k = 0; k < FL; k++) shadow[k] = 0;
  endtask

  task automatic test_basic();
    queue_coefs(1, 1, 1, 1);
    smp = '{1, 2, 3, 4};
    run_frame("basic", 0, 0, 1, 10, 0);
  endtask

  task automatic test_saturation();
    queue_coefs(7, -8, -8, 1);
    smp = '{2047, -2048, 2047, 0};
    run_frame("saturation", 0, 0, 1, 8190, 0);
  endtask

  task automatic test_overflow();
    queue_coefs(1, 1, 1, 1);
    smp = '{1, 0, 0, 0};
    run_frame("overflow", 16383, 0, 1, -16384, 1);
    smp = '{0, 0, 0, 0};
    run_frame("overflow_clear", 0, 0, 1, 0, 0);
  endtask

  task automatic test_stalls();
    smp = '{1, 2, 3, 4};
    run_frame("stalls", 0, 3, 1, 10, 0);
  endtask

  task automatic test_mid_frame_reset();
    bias = YW'(100);
    @(negedge clk);
    s_valid = 1'b1; s_data = SW'(1);
    @(negedge clk);
    s_data = SW'(2);
    @(negedge clk);
    reset = 1'b1; coef_we = 1'b1; coef_addr = CW'(1); coef_wdata = CFW'(5);
    @(negedge clk);
    check_reset_outputs("mid_reset");
    reset = 1'b0; coef_we = 1'b0; s_valid = 1'b0;
    for (int k = 0; k < FL; k++) shadow[k] = 0;
    smp = '{1, 1, 1, 1};
    run_frame("after_reset", 1234, 0, 1, 1234, 0);
  endtask

  task automatic test_coef_update();
    queue_coefs(1, 1, 1, 1);
    smp = '{1, 2, 3, 4};
    mid_at = 0; mid_addr = 0; mid_data = 2;
    run_frame("coef_update_cur", 0, 0, 1, 10, 0);
    run_frame("coef_update_next", 0, 0, 1, 11, 0);
  endtask

  task automatic test_random();
    for (int f = 0; f < 25; f++) begin
      for (int k = rnd(0, 4); k > 0; k--) begin
        pq_addr.push_back(rnd(0, FL - 1));
        pq_data.push_back(rnd(-8, 7));
      end
      for (int k = 0; k < FL; k++) smp[k] = rnd(-2048, 2047);
      if ($urandom_range(0, 1) == 1) begin
        mid_at = rnd(0, FL - 1); mid_addr = rnd(0, FL - 1); mid_data = rnd(-8, 7);
      end
      run_frame("random", rnd(YMIN, YMAX), -1, 0, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_overflow();
    test_stalls();
    test_mid_frame_reset();
    test_coef_update();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
